// File: rtl/fft_frame_sequencer.sv
// Ping-pong frame buffer between the decimator and the FFT front end.
// Two banks fill in turn; each full bank is streamed out as a valid/ready/last stream with a window index.
module fft_frame_sequencer #(
    parameter int FRAME_LEN = 1024,
    parameter int SAMPLE_W  = 16,
    localparam int IDX_W    = $clog2(FRAME_LEN)
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid_in,
    output logic signed [SAMPLE_W-1:0] fft_data_out,
    output logic                       fft_valid_out,
    input  logic                       fft_ready_in,
    output logic                       fft_last_out,
    output logic [IDX_W-1:0]           win_idx_out,
    output logic [7:0]                 overrun_count_out,
    output logic                       busy_out
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    localparam logic [IDX_W-1:0] PTR_MAX = IDX_W'(FRAME_LEN - 1);

    logic [SAMPLE_W-1:0] mem_q [2*FRAME_LEN];

    logic [1:0]          state_q, state_d;
    logic [1:0]          bank_full_q, bank_full_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]          ovr_q, ovr_d;
    logic [SAMPLE_W-1:0] rd_data_q;

    logic             wr_accept;
    logic             wr_drop;
    logic             beat_accept;
    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;

    assign wr_accept   = sample_valid_in && !bank_full_q[wr_bank_q];
    assign wr_drop     = sample_valid_in &&  bank_full_q[wr_bank_q];
    assign beat_accept = (state_q == ST_STREAM) && fft_ready_in;

    always_comb begin
        state_d     = state_q;
        bank_full_d = bank_full_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ovr_d       = ovr_q;
        rd_en       = 1'b0;
        rd_addr     = '0;

        // Write side only ever looks at the pre-edge full flags, so a sample racing the final beat is dropped.
        if (wr_accept) begin
            if (wr_ptr_q == PTR_MAX) begin
                bank_full_d[wr_bank_q] = 1'b1;
                wr_bank_d              = ~wr_bank_q;
                wr_ptr_d               = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end else if (wr_drop && ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (beat_accept) begin
                    if (rd_ptr_q == PTR_MAX) begin
                        bank_full_d[rd_bank_q] = 1'b0;
                        rd_bank_d              = ~rd_bank_q;
                        rd_ptr_d               = '0;
                        state_d                = ST_IDLE;
                    end else begin
                        // Prefetch the next word on the same edge the current beat leaves.
                        rd_en    = 1'b1;
                        rd_addr  = rd_ptr_q + 1'b1;
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in && wr_accept) begin
            mem_q[{wr_bank_q, wr_ptr_q}] <= sample_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= ST_IDLE;
            bank_full_q <= 2'b00;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ovr_q       <= 8'd0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bank_full_q <= bank_full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ovr_q       <= ovr_d;
            if (rd_en) begin
                rd_data_q <= mem_q[{rd_bank_q, rd_addr}];
            end
        end
    end

    assign fft_data_out      = rd_data_q;
    assign fft_valid_out     = (state_q == ST_STREAM);
    assign fft_last_out      = fft_valid_out && (rd_ptr_q == PTR_MAX);
    assign win_idx_out       = rd_ptr_q;
    assign overrun_count_out = ovr_q;
    assign busy_out          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with an 8-deep frame.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fft_frame_sequencer;

    logic        clkIn;
    logic        rstN;
    logic [15:0] sampleIn;
    logic        sampleValid;
    logic [15:0] fftData;
    logic        fftValid;
    logic        readyIn;
    logic        fftLast;
    logic [2:0]  winIdx;
    logic [7:0]  overrunCount;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int beatCnt;

    fft_frame_sequencer #(
        .FRAME_LEN(8),
        .SAMPLE_W (16)
    ) dut (
        .clk_in           (clkIn),
        .rst_in           (rstN),
        .sample_in        (sampleIn),
        .sample_valid_in  (sampleValid),
        .fft_data_out     (fftData),
        .fft_valid_out    (fftValid),
        .fft_ready_in     (readyIn),
        .fft_last_out     (fftLast),
        .win_idx_out      (winIdx),
        .overrun_count_out(overrunCount),
        .busy_out         (busy)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    task automatic tick();
        @(posedge clkIn);
        #1;
    endtask

    // One sample strobe lasting exactly one clock.
    task automatic applyStimulus(input int value);
        sampleValid = 1'b1;
        sampleIn    = 16'(value);
        tick();
        sampleValid = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Checks one full frame of beats starting at the current cycle, ready held high.
    task automatic checkFrame(input string tag, input int firstValue);
        for (int k = 0; k < 8; k++) begin
            checkOutput({tag, "_valid"}, int'(fftValid), 1);
            checkOutput({tag, "_data"}, int'(fftData), firstValue + k);
            checkOutput({tag, "_idx"}, int'(winIdx), k);
            checkOutput({tag, "_last"}, int'(fftLast), (k == 7) ? 1 : 0);
            tick();
        end
        checkOutput({tag, "_end_valid"}, int'(fftValid), 0);
    endtask

    // Writes values first..first+7, one every `spacing` cycles.
    task automatic fillFrame(input int first, input int spacing);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(first + i);
            if (i < 7) repeat (spacing - 1) tick();
        end
    endtask

    initial begin
        rstN        = 1'b0;
        sampleIn    = '0;
        sampleValid = 1'b0;
        readyIn     = 1'b0;

        $display("[TB] reset with samples pulsing");
        applyStimulus(77);
        applyStimulus(78);
        checkOutput("rst_valid", int'(fftValid), 0);
        checkOutput("rst_data", int'(fftData), 0);
        checkOutput("rst_idx", int'(winIdx), 0);
        checkOutput("rst_last", int'(fftLast), 0);
        checkOutput("rst_overrun", int'(overrunCount), 0);
        checkOutput("rst_busy", int'(busy), 0);

        $display("[TB] single frame");
        rstN    = 1'b1;
        readyIn = 1'b1;
        tick();
        fillFrame(1, 4);
        checkOutput("lat_e0_valid", int'(fftValid), 0);
        checkOutput("lat_e0_busy", int'(busy), 0);
        tick();
        checkOutput("lat_e1_valid", int'(fftValid), 0);
        checkOutput("lat_e1_busy", int'(busy), 1);
        tick();
        checkFrame("single", 1);
        checkOutput("single_busy_end", int'(busy), 0);

        $display("[TB] backpressure");
        fillFrame(1, 4);
        tick();
        tick();
        beatCnt = 0;
        for (int c = 0; c < 16; c++) begin
            if (beatCnt < 8) begin
                checkOutput("bp_valid", int'(fftValid), 1);
                checkOutput("bp_data", int'(fftData), beatCnt + 1);
                checkOutput("bp_idx", int'(winIdx), beatCnt);
                checkOutput("bp_last", int'(fftLast), (beatCnt == 7) ? 1 : 0);
            end
            readyIn = (c % 2 == 0);
            tick();
            if (readyIn) beatCnt++;
        end
        checkOutput("bp_beats", beatCnt, 8);
        checkOutput("bp_end_valid", int'(fftValid), 0);

        $display("[TB] overrun");
        readyIn = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            applyStimulus(i);
            tick();
        end
        checkOutput("ovr_count", int'(overrunCount), 8);
        checkOutput("ovr_stall_valid", int'(fftValid), 1);
        checkOutput("ovr_stall_data", int'(fftData), 1);
        readyIn = 1'b1;
        checkFrame("ovr_f0", 1);
        tick();
        checkOutput("ovr_gap_valid", int'(fftValid), 0);
        tick();
        checkFrame("ovr_f1", 9);
        repeat (6) tick();
        checkOutput("ovr_no_third", int'(fftValid), 0);

        $display("[TB] saturation");
        readyIn = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(i);
            tick();
        end
        checkOutput("sat_start", int'(overrunCount), 8);
        for (int i = 0; i < 246; i++) begin
            applyStimulus(i);
            tick();
        end
        checkOutput("sat_254", int'(overrunCount), 254);
        for (int i = 0; i < 54; i++) begin
            applyStimulus(i);
            tick();
        end
        checkOutput("sat_255", int'(overrunCount), 255);

        $display("[TB] reset mid-stream");
        rstN = 1'b0;
        tick();
        tick();
        checkOutput("rst2_overrun", int'(overrunCount), 0);
        checkOutput("rst2_valid", int'(fftValid), 0);
        rstN    = 1'b1;
        readyIn = 1'b1;
        fillFrame(1, 2);
        tick();
        tick();
        checkOutput("mid_first", int'(fftData), 1);
        applyStimulus(50);
        applyStimulus(51);
        applyStimulus(52);
        checkOutput("mid_beat4_data", int'(fftData), 4);
        checkOutput("mid_beat4_idx", int'(winIdx), 3);
        rstN = 1'b0;
        tick();
        checkOutput("mid_rst_valid", int'(fftValid), 0);
        checkOutput("mid_rst_busy", int'(busy), 0);
        checkOutput("mid_rst_idx", int'(winIdx), 0);
        rstN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(101 + i);
            tick();
            if (i < 7) checkOutput("fresh_no_early", int'(busy), 0);
        end
        checkOutput("fresh_e1_valid", int'(fftValid), 0);
        tick();
        checkFrame("fresh", 101);
        repeat (10) tick();
        checkOutput("fresh_alone", int'(fftValid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
